// File: rtl/fifo_arb_pkg.sv
// -----------------------------------------------------------------------------
// fifo_arb_pkg
//   Shared types and helpers for the write-port arbiter in front of
//   async_fifo1.
//
//   arb_state_t  : arbiter FSM encoding (IDLE / GRANT).
//   rr_pick_t    : result of a rotate-priority search (found flag + index).
//   rr_pick()    : first set request bit at or above ptr, wrapping at num_req.
//   NUM_REQ_DEF  : default requester count; IDW is its index width.
// -----------------------------------------------------------------------------
package fifo_arb_pkg;

  localparam int NUM_REQ_DEF = 4;
  localparam int IDW         = $clog2(NUM_REQ_DEF);

  // Upper bound on requesters; the search helper works on vectors of this
  // width so one function serves every legal NUM_REQ.
  localparam int MAX_REQ = 8;
  localparam int MAX_IDW = 3;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  typedef struct packed {
    logic               found;
    logic [MAX_IDW-1:0] idx;
  } rr_pick_t;

  // Walks num_req positions starting at ptr, wrapping from num_req-1 back to
  // 0, and returns the first set bit. Bits at or above num_req are ignored.
  function automatic rr_pick_t rr_pick(
    input logic [MAX_REQ-1:0] req,
    input logic [MAX_IDW-1:0] ptr,
    input int                 num_req
  );
    rr_pick_t           r;
    logic [MAX_IDW-1:0] pos;
    logic [MAX_IDW-1:0] last;
    r.found = 1'b0;
    r.idx   = '0;
    last    = MAX_IDW'(num_req - 1);
    pos     = ptr;
    for (int k = 0; k < MAX_REQ; k++) begin
      if (k < num_req && !r.found && req[pos]) begin
        r.found = 1'b1;
        r.idx   = pos;
      end
      pos = (pos == last) ? '0 : pos + 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// -----------------------------------------------------------------------------
// fifo_wr_arbiter_if
//   Bundles the producer handshakes and the FIFO write port seen by
//   fifo_wr_arbiter.
//
//   req_valid [NUM_REQ]        producer word-valid
//   req_data  [NUM_REQ*DSIZE]  producer data, requester i at [i*DSIZE +: DSIZE]
//   req_ready [NUM_REQ]        producer accept (one-hot or zero)
//   wfull                      FIFO full flag (wclk domain)
//   winc                       FIFO write enable
//   wdata     [DSIZE]          FIFO write data
//   grant_id  [$clog2(NUM_REQ)] current owner, meaningful while busy
//   busy                       arbiter is in GRANT
//
//   slave  : arbiter view.  master : producers + FIFO view.
// -----------------------------------------------------------------------------
interface fifo_wr_arbiter_if
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int DSIZE   = 8
);
  localparam int ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ*DSIZE-1:0] req_data;
  logic [NUM_REQ-1:0]       req_ready;
  logic                     wfull;
  logic                     winc;
  logic [DSIZE-1:0]         wdata;
  logic [ID_W-1:0]          grant_id;
  logic                     busy;

  modport slave (
    input  req_valid, req_data, wfull,
    output req_ready, winc, wdata, grant_id, busy
  );

  modport master (
    output req_valid, req_data, wfull,
    input  req_ready, winc, wdata, grant_id, busy
  );

endinterface

// File: rtl/fifo_wr_arbiter_rr_priority_sel.sv
// -----------------------------------------------------------------------------
// rr_priority_sel
//   Combinational rotate-priority encoder. Finds the first asserted request
//   at or above ptr, wrapping at NUM_REQ (non-power-of-two counts supported).
//
//   req [NUM_REQ]  request vector
//   ptr [ID_W]     search start index, must be < NUM_REQ
//   idx [ID_W]     selected index (0 when nothing is requested)
//   any            at least one request is set
// -----------------------------------------------------------------------------
module rr_priority_sel
  import fifo_arb_pkg::*;
#(
  parameter  int NUM_REQ = NUM_REQ_DEF,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [ID_W-1:0]    idx,
  output logic               any
);

  rr_pick_t pick;

  always_comb begin
    pick = rr_pick(MAX_REQ'(req), MAX_IDW'(ptr), NUM_REQ);
    idx  = ID_W'(pick.idx);
    any  = pick.found;
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// fifo_wr_arbiter
//   Round-robin owner of the async_fifo1 write port. NUM_REQ producers in the
//   wclk domain compete with valid/ready handshakes; the winner keeps the
//   port for up to MAX_BURST accepted words, then the grant rotates.
//
//   wclk    write-domain clock, rising edge
//   wrst_n  asynchronous active-low reset
//   bus     fifo_wr_arbiter_if.slave (producer handshakes + FIFO write port)
//
//   IDLE : pick the next owner (one cycle, no transfer).
//   GRANT: req_ready[owner] = ~wfull, winc = valid & ready, both
//          combinational so the FIFO samples them on the same edge.
//   Release (back to IDLE, pointer moves past the owner) on the last word of
//   a burst or when the owner drops valid. A full FIFO just holds the grant.
// -----------------------------------------------------------------------------
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ   = NUM_REQ_DEF,
  parameter int DSIZE     = 8,
  parameter int MAX_BURST = 4
) (
  input logic               wclk,
  input logic               wrst_n,
  fifo_wr_arbiter_if.slave  bus
);

  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(MAX_BURST) + 1;

  localparam logic [0:0] ST_IDLE  = 1'(IDLE);
  localparam logic [0:0] ST_GRANT = 1'(GRANT);

  localparam logic [ID_W-1:0]  LAST_ID  = ID_W'(NUM_REQ - 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_BURST - 1);

  logic [0:0]       state;
  logic [ID_W-1:0]  rr_ptr;
  logic [ID_W-1:0]  owner;
  logic [CNT_W-1:0] burst_cnt;

  logic [ID_W-1:0]  sel_idx;
  logic             sel_any;

  logic             in_grant;
  logic             owner_valid;
  logic             port_open;
  logic             xfer;
  logic             last_word;
  logic [ID_W-1:0]  next_ptr;

  rr_priority_sel #(
    .NUM_REQ (NUM_REQ)
  ) u_sel (
    .req (bus.req_valid),
    .ptr (rr_ptr),
    .idx (sel_idx),
    .any (sel_any)
  );

  // ---------------------------------------------------------------------------
  // Handshake and write port
  // ---------------------------------------------------------------------------
  assign in_grant    = (state == ST_GRANT);
  assign owner_valid = bus.req_valid[owner];
  assign port_open   = in_grant & ~bus.wfull;
  assign xfer        = port_open & owner_valid;
  assign last_word   = (burst_cnt == LAST_CNT);

  // Pointer lands just past the releasing owner so it goes last next round.
  assign next_ptr = (owner == LAST_ID) ? '0 : owner + 1'b1;

  // NOTE: every signal written in an always_comb gets a default on entry, so
  // no path leaves it unassigned and no latch is inferred.
  always_comb begin
    bus.req_ready = '0;
    if (port_open) begin
      bus.req_ready[owner] = 1'b1;
    end
  end

  // Data mux selects 0 outside GRANT so wdata idles at a known value.
  always_comb begin
    bus.wdata = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (in_grant && owner == ID_W'(i)) begin
        bus.wdata = bus.req_data[i*DSIZE +: DSIZE];
      end
    end
  end

  assign bus.winc     = xfer;
  assign bus.busy     = in_grant;
  assign bus.grant_id = owner;

  // ---------------------------------------------------------------------------
  // FSM, owner, pointer and burst counter
  // ---------------------------------------------------------------------------
  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  // NOTE: all four registers have an async reset; an assertion mid-burst drops
  // the FSM to IDLE at once, which kills winc and req_ready combinationally.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      state     <= ST_IDLE;
      rr_ptr    <= '0;
      owner     <= '0;
      burst_cnt <= '0;
    end else if (state == ST_IDLE) begin
      if (sel_any) begin
        owner     <= sel_idx;
        burst_cnt <= '0;
        state     <= ST_GRANT;
      end
    end else begin
      if (xfer && !last_word) begin
        burst_cnt <= burst_cnt + 1'b1;
      end else if (xfer || !owner_valid) begin
        // Burst exhausted or producer went quiet: hand the port on.
        state     <= ST_IDLE;
        rr_ptr    <= next_ptr;
        burst_cnt <= '0;
      end
      // Owner still valid but FIFO full: hold grant and count unchanged.
    end
  end

endmodule
